// File: rtl/change_dispense_ctrl.sv
// Coin-return sequencer: pays out change greedily (500/200/100) against a
// tracked coin inventory, one registered eject pulse per dispenser-ready cycle.
module change_dispense_ctrl #(
  parameter int AMT_W    = 8,
  parameter int CNT_W    = 8,
  parameter int INIT_CNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             disp_ready,
  input  logic             In100,
  input  logic             In200,
  input  logic             In500,
  output logic             Out100,
  output logic             Out200,
  output logic             Out500,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] rem_out,
  output logic [CNT_W-1:0] inv100,
  output logic [CNT_W-1:0] inv200,
  output logic [CNT_W-1:0] inv500,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, DISP = 1'b1} state_t;

  // Handshake: a coin is ejected only at an edge where disp_ready=1 while in
  // DISP; with disp_ready=0 the payout holds with no pulse and no state change.

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       out_q, out_d;  // {500, 200, 100}
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] inv100_q, inv100_d;
  logic [CNT_W-1:0] inv200_q, inv200_d;
  logic [CNT_W-1:0] inv500_q, inv500_d;
  logic             dec100, dec200, dec500;

  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Refill saturates at the top; a refill and eject of the same type cancel.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) r = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      r = cnt - CNT_W'(1);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    out_d   = 3'b000;
    done_d  = 1'b0;
    fault_d = 1'b0;
    dec100  = 1'b0;
    dec200  = 1'b0;
    dec500  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = amount;
          state_d = DISP;
        end
      end
      DISP: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (disp_ready) begin
          // Selection sees only the registered inventory; same-cycle refills land next cycle.
          if (rem_q >= AMT_W'(5) && inv500_q != '0) begin
            dec500 = 1'b1;
            out_d  = 3'b100;
            rem_d  = rem_q - AMT_W'(5);
          end else if (rem_q >= AMT_W'(2) && inv200_q != '0) begin
            dec200 = 1'b1;
            out_d  = 3'b010;
            rem_d  = rem_q - AMT_W'(2);
          end else if (inv100_q != '0) begin
            dec100 = 1'b1;
            out_d  = 3'b001;
            rem_d  = rem_q - AMT_W'(1);
          end else begin
            fault_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    inv100_d = next_cnt(inv100_q, In100, dec100);
    inv200_d = next_cnt(inv200_q, In200, dec200);
    inv500_d = next_cnt(inv500_q, In500, dec500);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      out_q    <= 3'b000;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      inv100_q <= INIT_VAL;
      inv200_q <= INIT_VAL;
      inv500_q <= INIT_VAL;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      inv100_q <= inv100_d;
      inv200_q <= inv200_d;
      inv500_q <= inv500_d;
    end
  end

  assign Out500    = out_q[2];
  assign Out200    = out_q[1];
  assign Out100    = out_q[0];
  assign busy      = (state_q == DISP);
  assign done      = done_q;
  assign fault     = fault_q;
  assign rem_out   = rem_q;
  assign inv100    = inv100_q;
  assign inv200    = inv200_q;
  assign inv500    = inv500_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: three instances (INIT_CNT 8, 1, 255)
// on one clock, inputs driven and outputs sampled 1ns after each rising edge.
module tb_change_dispense_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset[3], start[3], disp_ready[3], in100[3], in200[3], in500[3];
  logic [7:0] amount[3];
  logic       o100[3], o200[3], o500[3], busy[3], done[3], fault[3], dbg[3];
  logic [7:0] rem[3], inv100[3], inv200[3], inv500[3];

  int n_checks = 0;
  int n_fail   = 0;

  change_dispense_ctrl #(.AMT_W(8), .CNT_W(8), .INIT_CNT(8)) u_dut8 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .amount(amount[0]),
    .disp_ready(disp_ready[0]), .In100(in100[0]), .In200(in200[0]), .In500(in500[0]),
    .Out100(o100[0]), .Out200(o200[0]), .Out500(o500[0]), .busy(busy[0]),
    .done(done[0]), .fault(fault[0]), .rem_out(rem[0]), .inv100(inv100[0]),
    .inv200(inv200[0]), .inv500(inv500[0]), .dbg_state(dbg[0]));

  change_dispense_ctrl #(.AMT_W(8), .CNT_W(8), .INIT_CNT(1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .amount(amount[1]),
    .disp_ready(disp_ready[1]), .In100(in100[1]), .In200(in200[1]), .In500(in500[1]),
    .Out100(o100[1]), .Out200(o200[1]), .Out500(o500[1]), .busy(busy[1]),
    .done(done[1]), .fault(fault[1]), .rem_out(rem[1]), .inv100(inv100[1]),
    .inv200(inv200[1]), .inv500(inv500[1]), .dbg_state(dbg[1]));

  change_dispense_ctrl #(.AMT_W(8), .CNT_W(8), .INIT_CNT(255)) u_dut255 (
    .clk(clk), .reset(reset[2]), .start(start[2]), .amount(amount[2]),
    .disp_ready(disp_ready[2]), .In100(in100[2]), .In200(in200[2]), .In500(in500[2]),
    .Out100(o100[2]), .Out200(o200[2]), .Out500(o500[2]), .busy(busy[2]),
    .done(done[2]), .fault(fault[2]), .rem_out(rem[2]), .inv100(inv100[2]),
    .inv200(inv200[2]), .inv500(inv500[2]), .dbg_state(dbg[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] coins(input int i);
    return {o500[i], o200[i], o100[i]};
  endfunction

  task automatic check_inv(input string tag, input int i,
                           input int e500, input int e200, input int e100);
    check({tag, "_inv500"}, inv500[i], e500);
    check({tag, "_inv200"}, inv200[i], e200);
    check({tag, "_inv100"}, inv100[i], e100);
  endtask

  task automatic begin_payout(input int i, input logic [7:0] amt);
    amount[i] = amt;
    start[i]  = 1'b1;
    step();
    start[i]  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1; start[i] = 1'b0; disp_ready[i] = 1'b0;
      in100[i] = 1'b0; in200[i] = 1'b0; in500[i] = 1'b0; amount[i] = '0;
    end
    step();
    step();
    check("rst_busy", busy[0], 0);
    check("rst_coins", coins(0), 0);
    check("rst_done_fault", {done[0], fault[0]}, 0);
    check("rst_rem", rem[0], 0);
    check_inv("rst8", 0, 8, 8, 8);
    check_inv("rst1", 1, 1, 1, 1);
    check_inv("rst255", 2, 255, 255, 255);
    for (int i = 0; i < 3; i++) reset[i] = 1'b0;

    // Exact greedy payout of 8 = 500 + 200 + 100
    disp_ready[0] = 1'b1;
    begin_payout(0, 8'd8);
    check("t1_busy_e0", busy[0], 1);
    check("t1_dbg_e0", dbg[0], 1);
    check("t1_coins_e0", coins(0), 0);
    step();
    check("t1_coin_e1", coins(0), 3'b100);
    check("t1_rem_e1", rem[0], 3);
    step();
    check("t1_coin_e2", coins(0), 3'b010);
    check("t1_rem_e2", rem[0], 1);
    step();
    check("t1_coin_e3", coins(0), 3'b001);
    check("t1_rem_e3", rem[0], 0);
    check("t1_done_e3", done[0], 0);
    step();
    check("t1_done_e4", done[0], 1);
    check("t1_fault_e4", fault[0], 0);
    check("t1_busy_e4", busy[0], 0);
    check("t1_coins_e4", coins(0), 0);
    check_inv("t1", 0, 7, 7, 7);
    step();
    check("t1_done_e5", done[0], 0);

    // A start held during a payout is neither taken nor queued
    begin_payout(0, 8'd8);
    amount[0] = 8'd5;
    start[0]  = 1'b1;
    step();
    check("t4_coin_e1", coins(0), 3'b100);
    step();
    check("t4_coin_e2", coins(0), 3'b010);
    step();
    check("t4_coin_e3", coins(0), 3'b001);
    start[0] = 1'b0;
    step();
    check("t4_done_e4", done[0], 1);
    check_inv("t4", 0, 6, 6, 6);
    step();
    check("t4_idle_after", busy[0], 0);
    check("t4_coins_after", coins(0), 0);

    // Zero amount completes at once
    begin_payout(0, 8'd0);
    check("t4z_busy_e0", busy[0], 1);
    step();
    check("t4z_done_e1", done[0], 1);
    check("t4z_coins_e1", coins(0), 0);
    check("t4z_busy_e1", busy[0], 0);

    // Stall on disp_ready low for three edges
    begin_payout(0, 8'd3);
    disp_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_stall_coins", coins(0), 0);
      check("t3_stall_busy", busy[0], 1);
      check("t3_stall_rem", rem[0], 3);
    end
    disp_ready[0] = 1'b1;
    step();
    check("t3_coin_200", coins(0), 3'b010);
    step();
    check("t3_coin_100", coins(0), 3'b001);
    step();
    check("t3_done", done[0], 1);
    check_inv("t3", 0, 6, 5, 5);

    // Refill coinciding with a 100 eject leaves the count unchanged
    begin_payout(0, 8'd1);
    in100[0] = 1'b1;
    step();
    in100[0] = 1'b0;
    check("t5_coin_100", coins(0), 3'b001);
    check("t5_inv100_same", inv100[0], 5);
    step();
    check("t5_done", done[0], 1);
    in500[0] = 1'b1;
    step();
    in500[0] = 1'b0;
    check("t5_refill500", inv500[0], 7);

    // Saturating refill
    in200[2] = 1'b1;
    step();
    in200[2] = 1'b0;
    check("t5_sat_inv200", inv200[2], 255);
    check("t5_sat_inv100", inv100[2], 255);

    // Exhausted inventory with one coin of each type
    disp_ready[1] = 1'b1;
    begin_payout(1, 8'd6);
    step();
    check("t2a_coin_500", coins(1), 3'b100);
    step();
    check("t2a_coin_100", coins(1), 3'b001);
    step();
    check("t2a_done", done[1], 1);
    begin_payout(1, 8'd6);
    step();
    check("t2b_coin_200", coins(1), 3'b010);
    check("t2b_rem", rem[1], 4);
    step();
    check("t2b_fault", fault[1], 1);
    check("t2b_done", done[1], 0);
    check("t2b_busy", busy[1], 0);
    check("t2b_coins", coins(1), 0);
    check("t2b_rem_kept", rem[1], 4);
    check("t2b_inv200", inv200[1], 0);
    step();
    check("t2b_fault_pulse", fault[1], 0);
    check("t2b_rem_hold", rem[1], 4);

    // Reset in the cycle after the first coin
    begin_payout(0, 8'd8);
    step();
    check("t6_coin_e1", coins(0), 3'b100);
    reset[0] = 1'b1;
    step();
    reset[0] = 1'b0;
    check("t6_busy", busy[0], 0);
    check("t6_coins", coins(0), 0);
    check("t6_rem", rem[0], 0);
    check("t6_dbg", dbg[0], 0);
    check_inv("t6", 0, 8, 8, 8);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_quiet_coins", coins(0), 0);
      check("t6_quiet_busy", {busy[0], done[0], fault[0]}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
